// File: rtl/helper_axis_checker.sv
// AXI-Stream sequence checker: it expects an incrementing data stream, counts beats and mismatches,
// and stops when the beat limit is reached or on an error. Optional backpressure is enabled with HELPER_AXIS_CHECKER_STALL_EN.
module helper_axis_checker #(
  parameter int DATA_WIDTH    = 10,
  parameter int START_AT      = 0,
  parameter int BEAT_LIMIT    = 256,
  parameter int COUNT_WIDTH   = 16,
  parameter int STOP_ON_ERROR = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   input_valid,
  input  logic [DATA_WIDTH-1:0]  input_data,
  output logic                   input_ready,
  output logic [COUNT_WIDTH-1:0] beat_count,
  output logic [COUNT_WIDTH-1:0] error_count,
  output logic                   mismatch,
  output logic [DATA_WIDTH-1:0]  first_bad_data,
  output logic                   done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE, HALT} state_t;

  localparam int XW = COUNT_WIDTH + 32;
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [DATA_WIDTH-1:0]  START_VAL = DATA_WIDTH'(START_AT);
  localparam logic [XW-1:0]          LIMIT_X   = XW'(BEAT_LIMIT);

  state_t                  state, state_nxt;
  logic [DATA_WIDTH-1:0]   expected;
  logic                    stall, accept, bad, limit_hit;
  logic [COUNT_WIDTH-1:0]  beat_inc, err_inc;

`ifdef HELPER_AXIS_CHECKER_STALL_EN
  logic [15:0] lfsr;

  // Fibonacci LFSR with taps 16,14,13,11. It only advances while running, so the stall pattern restarts on every reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              lfsr <= 16'hACE1;
    else if (state == RUN) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign stall = (lfsr[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  assign input_ready = (state == RUN) && enable && !stall;
  assign accept      = input_valid && input_ready;
  assign bad         = (input_data != expected);
  assign beat_inc    = (beat_count  == CNT_MAX) ? beat_count  : beat_count  + 1'b1;
  assign err_inc     = (error_count == CNT_MAX) ? error_count : error_count + 1'b1;
  assign limit_hit   = (BEAT_LIMIT != 0) && (XW'(beat_inc) == LIMIT_X);
  assign done        = (state == DONE) || (state == HALT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (enable) state_nxt = RUN;
      RUN: begin
        if (accept) begin
          // A halt caused by an error takes priority over reaching the limit on the same beat.
          if ((STOP_ON_ERROR != 0) && bad) state_nxt = HALT;
          else if (limit_hit)              state_nxt = DONE;
        end
      end
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      expected       <= START_VAL;
      beat_count     <= '0;
      error_count    <= '0;
      mismatch       <= 1'b0;
      first_bad_data <= '0;
    end else if (accept) begin
      beat_count <= beat_inc;
      // On a match this equals expected+1. On a mismatch it resyncs to the received value, so a single dropped beat counts as one error.
      expected   <= input_data + 1'b1;
      if (bad) begin
        error_count <= err_inc;
        mismatch    <= 1'b1;
        if (!mismatch) first_bad_data <= input_data;
      end
    end
  end

endmodule

// File: tb/tb_helper_axis_checker.sv
// Bench for helper_axis_checker: three configurations share one stream and are checked each cycle against a
// beat-level model, plus fixed literal expectations for the directed scenarios.
module tb_helper_axis_checker;

  localparam int P_SA   [3] = '{14, 0, 3};
  localparam int P_LIM  [3] = '{6, 0, 0};
  localparam int P_CMAX [3] = '{255, 255, 15};
  localparam int P_STOP [3] = '{0, 1, 0};
`ifdef HELPER_AXIS_CHECKER_STALL_EN
  localparam bit STALL_ON = 1'b1;
`else
  localparam bit STALL_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic       input_valid = 1'b0;
  logic [3:0] input_data = '0;

  logic       rdy_a, rdy_b, rdy_c, mis_a, mis_b, mis_c, done_a, done_b, done_c;
  logic [7:0] bc_a, ec_a, bc_b, ec_b;
  logic [3:0] bc_c, ec_c, fbd_a, fbd_b, fbd_c;

  int checks = 0;
  int errors = 0;

  bit         m_started [3];
  bit         m_term    [3];
  bit         m_mis     [3];
  bit         m_acc     [3];
  int         m_exp     [3];
  int         m_bc      [3];
  int         m_ec      [3];
  int         m_fbd     [3];
  logic [15:0] m_lf     [3];
  string      names     [6] = '{"ready", "beat_count", "error_count", "mismatch", "first_bad_data", "done"};

  always #5 clk = ~clk;

  helper_axis_checker #(.DATA_WIDTH(4), .START_AT(14), .BEAT_LIMIT(6), .COUNT_WIDTH(8), .STOP_ON_ERROR(0)) dut_a (
    .clk(clk), .rst(rst), .enable(enable), .input_valid(input_valid), .input_data(input_data),
    .input_ready(rdy_a), .beat_count(bc_a), .error_count(ec_a), .mismatch(mis_a),
    .first_bad_data(fbd_a), .done(done_a));

  helper_axis_checker #(.DATA_WIDTH(4), .START_AT(0), .BEAT_LIMIT(0), .COUNT_WIDTH(8), .STOP_ON_ERROR(1)) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .input_valid(input_valid), .input_data(input_data),
    .input_ready(rdy_b), .beat_count(bc_b), .error_count(ec_b), .mismatch(mis_b),
    .first_bad_data(fbd_b), .done(done_b));

  helper_axis_checker #(.DATA_WIDTH(4), .START_AT(3), .BEAT_LIMIT(0), .COUNT_WIDTH(4), .STOP_ON_ERROR(0)) dut_c (
    .clk(clk), .rst(rst), .enable(enable), .input_valid(input_valid), .input_data(input_data),
    .input_ready(rdy_c), .beat_count(bc_c), .error_count(ec_c), .mismatch(mis_c),
    .first_bad_data(fbd_c), .done(done_c));

  task automatic cmp(string nm, int inst, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s inst %0d got %0d want %0d at %0t", nm, inst, act, exp, $time);
    end
  endtask

  // One clock cycle. At the falling edge, compare every instance with the model, then advance
  // the model to match what the next rising edge will do. Return 1 time unit after that rising edge.
  task automatic step();
    int act [3][6];
    int expv [6];
    bit stall, rdy, bad;
    int d;
    @(negedge clk);
    act[0] = '{int'(rdy_a), int'(bc_a), int'(ec_a), int'(mis_a), int'(fbd_a), int'(done_a)};
    act[1] = '{int'(rdy_b), int'(bc_b), int'(ec_b), int'(mis_b), int'(fbd_b), int'(done_b)};
    act[2] = '{int'(rdy_c), int'(bc_c), int'(ec_c), int'(mis_c), int'(fbd_c), int'(done_c)};
    d = int'(input_data);
    for (int i = 0; i < 3; i++) begin
      if (!rst) begin
        m_started[i] = 0; m_term[i] = 0; m_mis[i] = 0;
        m_exp[i] = P_SA[i]; m_bc[i] = 0; m_ec[i] = 0; m_fbd[i] = 0; m_lf[i] = 16'hACE1;
      end
      stall = STALL_ON && (m_lf[i][1:0] == 2'b00);
      rdy   = rst && m_started[i] && !m_term[i] && enable && !stall;
      expv  = '{int'(rdy), m_bc[i], m_ec[i], int'(m_mis[i]), m_fbd[i], int'(m_term[i])};
      for (int k = 0; k < 6; k++) cmp(names[k], i, act[i][k], expv[k]);
      m_acc[i] = rdy && input_valid;
      if (rst) begin
        if (!m_started[i]) begin
          if (enable) m_started[i] = 1;
        end else if (!m_term[i]) begin
          m_lf[i] = {m_lf[i][14:0], m_lf[i][15] ^ m_lf[i][13] ^ m_lf[i][12] ^ m_lf[i][10]};
          if (m_acc[i]) begin
            bad = (d != m_exp[i]);
            if (m_bc[i] < P_CMAX[i]) m_bc[i]++;
            if (bad) begin
              if (m_ec[i] < P_CMAX[i]) m_ec[i]++;
              if (!m_mis[i]) m_fbd[i] = d;
              m_mis[i] = 1;
            end
            m_exp[i] = (d + 1) % 16;
            if (bad && P_STOP[i] != 0)                 m_term[i] = 1;
            else if (P_LIM[i] != 0 && m_bc[i] == P_LIM[i]) m_term[i] = 1;
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Keep the beat valid until instance 'sel' has taken it. The wait is limited so the bench cannot hang.
  task automatic send(int sel, int d);
    int n;
    input_valid = 1'b1;
    input_data  = 4'(d);
    n = 0;
    do begin
      step();
      n++;
    end while (!m_acc[sel] && n < 60);
    if (!m_acc[sel]) begin
      checks++; errors++;
      $display("FAIL send_timeout inst %0d data %0d got no handshake want one within 60 cycles", sel, d);
    end
    input_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    input_valid = 1'b1;
    step();
    rst = 1'b1;
    input_valid = 1'b0;
  endtask

  initial begin
    step();
    step();
    cmp("reset_beat_count", 0, int'(bc_a), 0);
    cmp("reset_ready", 0, int'(rdy_a), 0);
    cmp("reset_done", 0, int'(done_a), 0);
    cmp("reset_fbd", 2, int'(fbd_c), 0);
    rst = 1'b1;
    enable = 1'b1;

    // A run with the limit set and a 4-bit wrap: 14,15,0,1,2,3 should produce no errors.
    foreach (P_SA[k]) if (k == 0) for (int v = 14; v < 20; v++) send(0, v % 16);
    step();
    cmp("lim_beat_count", 0, int'(bc_a), 6);
    cmp("lim_error_count", 0, int'(ec_a), 0);
    cmp("lim_done", 0, int'(done_a), 1);
    cmp("lim_ready", 0, int'(rdy_a), 0);
    cmp("lim_mismatch", 0, int'(mis_a), 0);

    // A single dropped beat should count as exactly one error, with the first bad value captured.
    pulse_reset();
    send(0, 14); send(0, 15); send(0, 0); send(0, 2); send(0, 3); send(0, 4);
    step();
    cmp("drop_error_count", 0, int'(ec_a), 1);
    cmp("drop_first_bad", 0, int'(fbd_a), 2);
    cmp("drop_mismatch", 0, int'(mis_a), 1);
    cmp("drop_beat_count", 0, int'(bc_a), 6);

    // With stop-on-error set: the sequence 0,1,7 halts the instance, and ready stays low afterwards.
    pulse_reset();
    send(1, 0); send(1, 1); send(1, 7);
    input_valid = 1'b1;
    repeat (5) step();
    input_valid = 1'b0;
    cmp("halt_beat_count", 1, int'(bc_b), 3);
    cmp("halt_error_count", 1, int'(ec_b), 1);
    cmp("halt_first_bad", 1, int'(fbd_b), 7);
    cmp("halt_ready", 1, int'(rdy_b), 0);
    cmp("halt_done", 1, int'(done_b), 1);

    // A mid-stream reset throws away all progress. The beat held during reset must not be counted.
    pulse_reset();
    send(2, 3); send(2, 4); send(2, 5);
    cmp("pre_rst_beats", 2, int'(bc_c), 3);
    input_data = 4'd6;
    pulse_reset();
    cmp("in_rst_beats", 2, int'(bc_c), 0);
    send(2, 3); send(2, 4); send(2, 5);
    cmp("post_rst_beats", 2, int'(bc_c), 3);
    cmp("post_rst_errors", 2, int'(ec_c), 0);
    cmp("post_rst_mismatch", 2, int'(mis_c), 0);

    // Random traffic: pauses, gaps, mostly in-order data, occasional bad values and resets.
    for (int k = 0; k < 4000; k++) begin
      enable      = ($urandom % 8) != 0;
      input_valid = ($urandom % 4) != 0;
      input_data  = (($urandom % 6) == 0) ? 4'($urandom) : 4'(m_exp[2]);
      rst         = ($urandom % 250) != 0;
      step();
    end
    rst = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/helper_axis_checker.md
HELPER_AXIS_CHECKER -- requirements
Module: helper_axis_checker

Interface
REQ-001 Parameter DATA_WIDTH, default 10, width of the stream data word.
REQ-002 Parameter START_AT, default 0, first expected data value after reset.
REQ-003 Parameter BEAT_LIMIT, default 256, number of accepted beats before completion; 0 = unlimited.
REQ-004 Parameter COUNT_WIDTH, default 16, width of the beat and error counters.
REQ-005 Parameter STOP_ON_ERROR, default 0, nonzero = halt on first mismatch.
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 enable  input  1  high = checker may accept beats; low = pause.
REQ-009 input_valid  input  1  AXIS TVALID from the upstream source.
REQ-010 input_data  input  DATA_WIDTH  AXIS TDATA from the upstream source.
REQ-011 input_ready  output  1  AXIS TREADY to the upstream source.
REQ-012 beat_count  output  COUNT_WIDTH  number of accepted beats.
REQ-013 error_count  output  COUNT_WIDTH  number of accepted beats that mismatched.
REQ-014 mismatch  output  1  sticky flag, set on the first mismatch.
REQ-015 first_bad_data  output  DATA_WIDTH  data value of the first mismatching beat.
REQ-016 done  output  1  high in DONE or HALT state.

Function
REQ-017 The FSM SHALL have states IDLE, RUN, DONE, HALT; IDLE -> RUN on the first clock edge with enable=1.
REQ-018 input_ready SHALL be combinational: 1 only when state=RUN and enable=1 (and not stalled, see REQ-031); 0 in IDLE, DONE, HALT.
REQ-019 A beat SHALL be accepted on an edge where input_valid=1 and input_ready=1; nothing changes without a handshake.
REQ-020 On an accepted beat, beat_count SHALL increment by 1, saturating at all-ones.
REQ-021 On an accepted beat, input_data SHALL be compared against the expected register; on a match, expected <= expected+1 modulo 2^DATA_WIDTH (wraps to 0).
REQ-022 On a mismatch, error_count SHALL increment (saturating), mismatch SHALL be set, and expected SHALL resync to input_data+1 (mod 2^DATA_WIDTH), so one dropped beat yields exactly one error.
REQ-023 first_bad_data SHALL capture input_data only on the mismatch that sets mismatch; later mismatches SHALL NOT overwrite it.
REQ-024 If BEAT_LIMIT!=0, the accept edge that brings beat_count to BEAT_LIMIT SHALL move RUN -> DONE; that beat is still checked and counted.
REQ-025 If STOP_ON_ERROR!=0, a mismatching accepted beat SHALL move RUN -> HALT (HALT takes precedence over DONE on the same edge).
REQ-026 enable=0 in RUN SHALL hold all state (pause) and force input_ready=0; enable has no effect in DONE/HALT.
REQ-027 DONE and HALT SHALL be terminal until reset; done=1 in both.

Reset
REQ-028 rst=0 SHALL asynchronously force state=IDLE, expected=START_AT, beat_count=0, error_count=0, mismatch=0, first_bad_data=0, done=0, input_ready=0.
REQ-029 Reset asserted mid-stream SHALL discard all progress; any beat presented in that cycle SHALL NOT be counted.
REQ-030 Release of rst SHALL be sampled synchronously; the first state change occurs no earlier than the first rising edge after release.

Configuration
REQ-031 With HELPER_AXIS_CHECKER_STALL_EN defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1, reloaded by reset) SHALL advance every cycle in RUN, and input_ready SHALL be forced 0 in any cycle where lfsr[1:0]==2'b00 (~25% backpressure).
REQ-032 Without HELPER_AXIS_CHECKER_STALL_EN: no LFSR is built and input_ready follows REQ-018 with no stall term.

Verification
REQ-033 START_AT=0, BEAT_LIMIT=8, source always valid sending 0..7 -> beat_count=8, error_count=0, mismatch=0, done=1, input_ready=0 after the 8th beat.
REQ-034 DATA_WIDTH=4, START_AT=14, BEAT_LIMIT=4, data 14,15,0,1 -> error_count=0 (wrap accepted), done=1.
REQ-035 BEAT_LIMIT=6, data 0,1,2,4,5,6 -> error_count=1, first_bad_data=4, mismatch=1, beat_count=6.
REQ-036 STOP_ON_ERROR=1, data 0,1,7,... -> HALT after 3rd beat, beat_count=3, error_count=1, first_bad_data=7, input_ready stays 0.
REQ-037 rst driven low for one cycle after 3 beats, then 0,1,2 resent -> counters restart, expected=START_AT, error_count=0; with STALL_EN defined, input_ready shows stall cycles yet all beats are received in order.
